// File: rtl/mux_somador_pkg.sv
// Shared types and helpers for the selectable-operand adder pipeline.
package mux_somador_pkg;

  // Operation encoding carried alongside each transaction.
  typedef enum logic [1:0] {
    SOMA  = 2'b00,
    SUB   = 2'b01,
    ACUM  = 2'b10,
    LIMPA = 2'b11
  } modo_e;

  localparam int MODO_W    = 2;
  // Widest result the saturating helper handles; callers zero-extend into it.
  localparam int SAT_MAX_W = 32;

  // Saturating unsigned add on the low w bits.
  // Bit SAT_MAX_W of the return value is the saturation flag, the low bits
  // hold the (possibly clamped) sum. Bits at and above w are always zero.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int                   w
  );
    logic [SAT_MAX_W:0] full;
    logic [SAT_MAX_W:0] one;
    logic [SAT_MAX_W:0] lim;
    full = {1'b0, a} + {1'b0, b};
    one  = {{SAT_MAX_W{1'b0}}, 1'b1};
    lim  = (one << w) - one;
    if (full > lim) begin
      sat_add = {1'b1, lim[SAT_MAX_W-1:0]};
    end else begin
      sat_add = {1'b0, full[SAT_MAX_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/mux_somador_pipe_mux_n.sv
// Parametrised N:1 combinational mux; out-of-range selects yield zero.
module mux_n #(
  parameter int  LARGURA    = 4,
  parameter int  N_ENTRADAS = 4,
  localparam int SEL_W      = $clog2(N_ENTRADAS)
) (
  input  logic [N_ENTRADAS*LARGURA-1:0] entradas,
  input  logic [SEL_W-1:0]              sel,
  output logic [LARGURA-1:0]            saida
);

  // Pick the matching slice; no match (select beyond the last entry) leaves zero.
  always_comb begin
    saida = '0;
    for (int i = 0; i < N_ENTRADAS; i++) begin
      if (sel == SEL_W'(i)) begin
        saida = entradas[i*LARGURA +: LARGURA];
      end
    end
  end

endmodule

// File: rtl/mux_somador_pipe.sv
// Operand select + add/sub/saturating-accumulate/clear, two-stage
// valid/ready pipeline between the register-file read path and result bus.
module mux_somador_pipe
  import mux_somador_pkg::*;
#(
  parameter int  LARGURA    = 4,
  parameter int  N_ENTRADAS = 4,
  localparam int SEL_W      = $clog2(N_ENTRADAS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          entrada_valida,
  output logic                          entrada_pronta,
  input  logic [LARGURA-1:0]            entradaA,
  input  logic [N_ENTRADAS*LARGURA-1:0] entradas,
  input  logic [SEL_W-1:0]              sel_mux,
  input  logic [MODO_W-1:0]             modo,
  output logic                          saida_valida,
  input  logic                          saida_pronta,
  output logic [LARGURA:0]              resultado_final,
  output logic                          estouro
);

  localparam int RES_W = LARGURA + 1;

  logic [LARGURA-1:0] op_sel;

  logic               vld_p1_q, vld_p1_d;
  logic [LARGURA-1:0] a_p1_q, a_p1_d;
  logic [LARGURA-1:0] op_p1_q, op_p1_d;
  modo_e              modo_p1_q, modo_p1_d;

  logic               vld_p2_q, vld_p2_d;
  logic [RES_W-1:0]   res_p2_q, res_p2_d;
  logic               est_p2_q, est_p2_d;
  logic [RES_W-1:0]   acc_q, acc_d;

  logic               pronta_p1, pronta_p2;
  logic               xfer_in, xfer_12;
  logic [RES_W-1:0]   a_ext, op_ext;
  logic [SAT_MAX_W:0] sat_res;

  mux_n #(
    .LARGURA    (LARGURA),
    .N_ENTRADAS (N_ENTRADAS)
  ) u_mux (
    .entradas (entradas),
    .sel      (sel_mux),
    .saida    (op_sel)
  );

  // Handshake: a stage accepts when empty or when its successor drains.
  always_comb begin
    pronta_p2      = !vld_p2_q | saida_pronta;
    pronta_p1      = !vld_p1_q | pronta_p2;
    entrada_pronta = pronta_p1 & !reset;
    xfer_in        = entrada_valida & entrada_pronta;
    xfer_12        = vld_p1_q & pronta_p2;
  end

  // ---- stage 1: capture A, selected operand and mode ----
  always_comb begin
    vld_p1_d  = vld_p1_q;
    a_p1_d    = a_p1_q;
    op_p1_d   = op_p1_q;
    modo_p1_d = modo_p1_q;
    if (pronta_p1) begin
      vld_p1_d = entrada_valida;
    end
    if (xfer_in) begin
      a_p1_d    = entradaA;
      op_p1_d   = op_sel;
      modo_p1_d = modo_e'(modo);
    end
  end

  // ---- stage 2: arithmetic on the S1->S2 transfer, output registers ----
  always_comb begin
    a_ext    = {1'b0, a_p1_q};
    op_ext   = {1'b0, op_p1_q};
    sat_res  = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(op_p1_q), RES_W);
    vld_p2_d = vld_p2_q;
    res_p2_d = res_p2_q;
    est_p2_d = est_p2_q;
    acc_d    = acc_q;
    if (pronta_p2) begin
      vld_p2_d = vld_p1_q;
    end
    if (xfer_12) begin
      unique case (modo_p1_q)
        SOMA: begin
          res_p2_d = a_ext + op_ext;
          est_p2_d = 1'b0;
        end
        SUB: begin
          res_p2_d = a_ext - op_ext;
          est_p2_d = (a_p1_q < op_p1_q);
        end
        ACUM: begin
          res_p2_d = sat_res[RES_W-1:0];
          // Bits above RES_W are zero by construction; folding them in keeps
          // the flag honest should the helper ever be widened.
          est_p2_d = sat_res[SAT_MAX_W] | (|sat_res[SAT_MAX_W-1:RES_W]);
          acc_d    = sat_res[RES_W-1:0];
        end
        default: begin
          res_p2_d = '0;
          est_p2_d = 1'b0;
          acc_d    = '0;
        end
      endcase
    end
  end

  // Control, accumulator and visible outputs: cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
      est_p2_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      res_p2_q <= res_p2_d;
      est_p2_q <= est_p2_d;
      acc_q    <= acc_d;
    end
  end

  // Stage-1 data path: only meaningful while vld_p1_q is set, so no reset.
  always_ff @(posedge clk) begin
    a_p1_q    <= a_p1_d;
    op_p1_q   <= op_p1_d;
    modo_p1_q <= modo_p1_d;
  end

  assign saida_valida    = vld_p2_q;
  assign resultado_final = res_p2_q;
  assign estouro         = est_p2_q;

endmodule

// File: tb/tb_mux_somador_pipe.sv
// Directed bench for mux_somador_pipe (4x4 instance plus a 3-entry instance).
module tb_mux_somador_pipe;

  logic        clk = 1'b0;
  logic        reset;
  // 4-entry instance
  logic        entrada_valida, entrada_pronta;
  logic [3:0]  entradaA;
  logic [15:0] entradas;
  logic [1:0]  sel_mux, modo;
  logic        saida_valida, saida_pronta, estouro;
  logic [4:0]  resultado_final;
  // 3-entry instance
  logic        v3_in, p3_in;
  logic [3:0]  a3;
  logic [11:0] ents3;
  logic [1:0]  sel3, modo3;
  logic        v3_out, p3_out, est3;
  logic [4:0]  res3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux_somador_pipe #(.LARGURA(4), .N_ENTRADAS(4)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .entrada_valida  (entrada_valida),
    .entrada_pronta  (entrada_pronta),
    .entradaA        (entradaA),
    .entradas        (entradas),
    .sel_mux         (sel_mux),
    .modo            (modo),
    .saida_valida    (saida_valida),
    .saida_pronta    (saida_pronta),
    .resultado_final (resultado_final),
    .estouro         (estouro)
  );

  mux_somador_pipe #(.LARGURA(4), .N_ENTRADAS(3)) u_dut3 (
    .clk             (clk),
    .reset           (reset),
    .entrada_valida  (v3_in),
    .entrada_pronta  (p3_in),
    .entradaA        (a3),
    .entradas        (ents3),
    .sel_mux         (sel3),
    .modo            (modo3),
    .saida_valida    (v3_out),
    .saida_pronta    (p3_out),
    .resultado_final (res3),
    .estouro         (est3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction on the 4-entry instance, checked two edges later.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] op,
                       input logic [1:0] sel, input logic [1:0] m,
                       input logic [4:0] exp_res, input logic exp_est);
    logic [15:0] e;
    e = '0;
    e[sel*4 +: 4] = op;
    entradaA = a; entradas = e; sel_mux = sel; modo = m;
    entrada_valida = 1'b1;
    tick();
    entrada_valida = 1'b0;
    tick();
    check_val({tag, "_vld"}, 32'(saida_valida), 32'd1);
    check_val({tag, "_res"}, 32'(resultado_final), 32'(exp_res));
    check_val({tag, "_est"}, 32'(estouro), 32'(exp_est));
    tick();
  endtask

  logic [4:0] acum_exp [4] = '{5'd15, 5'd30, 5'd31, 5'd31};
  logic       acum_est [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0] bp_op    [4] = '{4'd1, 4'd3, 4'd5, 4'd7};
  logic [4:0] bp_exp   [4] = '{5'd3, 5'd5, 5'd7, 5'd9};

  initial begin
    int  sent, got;
    logic acc_now, drn_now;
    reset = 1'b1; entrada_valida = 1'b0; entradaA = '0; entradas = '0;
    sel_mux = '0; modo = '0; saida_pronta = 1'b1;
    v3_in = 1'b0; a3 = '0; ents3 = '0; sel3 = '0; modo3 = '0; p3_out = 1'b1;
    tick(); tick();
    check_val("rst_vld", 32'(saida_valida), 32'd0);
    check_val("rst_res", 32'(resultado_final), 32'd0);
    check_val("rst_est", 32'(estouro), 32'd0);
    check_val("rst_pronta_low", 32'(entrada_pronta), 32'd0);
    reset = 1'b0;
    #1;
    check_val("rst_pronta_high", 32'(entrada_pronta), 32'd1);

    // SOMA / SUB
    do_op("soma1", 4'd3, 4'd5, 2'd1, 2'b00, 5'b01000, 1'b0);
    do_op("soma2", 4'd7, 4'd2, 2'd2, 2'b00, 5'b01001, 1'b0);
    do_op("sub1",  4'd2, 4'd5, 2'd0, 2'b01, 5'b11101, 1'b1);
    do_op("sub2",  4'd9, 4'd4, 2'd3, 2'b01, 5'b00101, 1'b0);

    // Four back-to-back saturating accumulates of 15
    entradaA = 4'd0; entradas = 16'h000F; sel_mux = 2'd0; modo = 2'b10;
    entrada_valida = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) entrada_valida = 1'b0;
      if (i >= 1) begin
        check_val($sformatf("acum%0d_vld", i), 32'(saida_valida), 32'd1);
        check_val($sformatf("acum%0d_res", i), 32'(resultado_final), 32'(acum_exp[i-1]));
        check_val($sformatf("acum%0d_est", i), 32'(estouro), 32'(acum_est[i-1]));
      end
    end
    tick();
    do_op("limpa",  4'd9, 4'd7, 2'd1, 2'b11, 5'd0, 1'b0);
    do_op("acum3",  4'd9, 4'd3, 2'd2, 2'b10, 5'd3, 1'b0);

    // Back-pressure: downstream stalled for the first four cycles
    sent = 0; got = 0;
    entradaA = 4'd2; sel_mux = 2'd0; modo = 2'b00;
    for (int c = 0; c < 12; c++) begin
      entrada_valida = (sent < 4);
      entradas = (sent < 4) ? {12'd0, bp_op[sent]} : 16'd0;
      saida_pronta = (c >= 4);
      #1;
      if (c == 2 || c == 3) begin
        check_val($sformatf("bp_pronta_c%0d", c), 32'(entrada_pronta), 32'd0);
        check_val($sformatf("bp_sent_c%0d", c), 32'(sent), 32'd2);
        check_val($sformatf("bp_hold_vld_c%0d", c), 32'(saida_valida), 32'd1);
        check_val($sformatf("bp_hold_res_c%0d", c), 32'(resultado_final), 32'(bp_exp[0]));
      end
      acc_now = entrada_valida & entrada_pronta;
      drn_now = saida_valida & saida_pronta;
      if (drn_now) begin
        if (got < 4) check_val($sformatf("bp_out%0d", got), 32'(resultado_final), 32'(bp_exp[got]));
        got++;
      end
      tick();
      if (acc_now) sent++;
    end
    entrada_valida = 1'b0;
    check_val("bp_sent_total", 32'(sent), 32'd4);
    check_val("bp_got_total", 32'(got), 32'd4);
    check_val("bp_idle", 32'(saida_valida), 32'd0);

    // Reset with a full pipeline of accumulates
    saida_pronta = 1'b0;
    entradas = 16'h0001; sel_mux = 2'd0; modo = 2'b10; entrada_valida = 1'b1;
    tick(); tick();
    entrada_valida = 1'b0;
    check_val("mid_full_vld", 32'(saida_valida), 32'd1);
    check_val("mid_full_pronta", 32'(entrada_pronta), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    saida_pronta = 1'b1;
    #1;
    check_val("mid_rst_vld", 32'(saida_valida), 32'd0);
    check_val("mid_rst_res", 32'(resultado_final), 32'd0);
    check_val("mid_rst_pronta", 32'(entrada_pronta), 32'd1);
    do_op("post_rst_acum", 4'd0, 4'd4, 2'd0, 2'b10, 5'd4, 1'b0);

    // Out-of-range select on the 3-entry instance, with an in-range control
    ents3 = {4'd9, 4'd8, 4'd7}; a3 = 4'd6; modo3 = 2'b00;
    sel3 = 2'd3; v3_in = 1'b1;
    tick();
    sel3 = 2'd2;
    tick();
    v3_in = 1'b0;
    check_val("oor_vld", 32'(v3_out), 32'd1);
    check_val("oor_res", 32'(res3), 32'd6);
    tick();
    check_val("inrange_res", 32'(res3), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
